// File: rtl/filter_len_scheduler_if.sv
// filter_len_scheduler_if: host config, commit handshake and filter-bank signals of the length scheduler.
interface filter_len_scheduler_if #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_chan;
  logic                   cfg_all;
  logic [31:0]            cfg_len;
  logic                   commit_req;
  logic                   commit_ack;
  logic                   busy;
  logic [NUM_CH-1:0]      filtered_in;
  logic [32*NUM_CH-1:0]   filter_len_out;
  logic [NUM_CH-1:0]      load_filter_len;
  logic                   clamp_flag;
  logic                   chan_err_flag;
  logic                   timeout_flag;
  logic                   clear_flags;
  modport master (
    output cfg_valid, cfg_chan, cfg_all, cfg_len, commit_req, filtered_in, clear_flags,
    input  cfg_ready, commit_ack, busy, filter_len_out, load_filter_len, clamp_flag, chan_err_flag, timeout_flag
  );
  modport slave (
    input  cfg_valid, cfg_chan, cfg_all, cfg_len, commit_req, filtered_in, clear_flags,
    output cfg_ready, commit_ack, busy, filter_len_out, load_filter_len, clamp_flag, chan_err_flag, timeout_flag
  );
endinterface

// File: rtl/filter_len_scheduler.sv
// filter_len_scheduler: clamped per-channel shadow filter lengths, applied to the bank in one atomic load pulse.
// Define FILTER_SCHED_QUIET_WAIT_EN to hold the apply until filtered_in has been quiet (bounded by a timeout).
module filter_len_scheduler #(
  parameter int          NUM_CH         = 3,
  parameter int          CH_W           = 2,
  parameter logic [31:0] DEFAULT_LEN    = 32'd50000,
  parameter logic [31:0] MIN_LEN        = 32'd10,
  parameter logic [31:0] MAX_LEN        = 32'd1000000,
  parameter int          QUIET_CYCLES   = 64,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input logic                   clk,
  input logic                   reset,
  filter_len_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd2;
  logic [1:0]        r_state, w_next;
  logic [31:0]       r_len [NUM_CH];
  logic [NUM_CH-1:0] r_dirty, w_wr_mask;
  logic              r_clamp, r_chan_err;
  logic              w_idle, w_apply, w_accept, w_chan_bad, w_wr, w_lo, w_hi;
  logic [31:0]       w_len;
  assign w_idle     = r_state == S_IDLE;
  assign w_apply    = r_state == S_APPLY;
  assign w_accept   = bus.cfg_valid && w_idle;
  assign w_chan_bad = 32'(bus.cfg_chan) >= 32'(NUM_CH);
  assign w_wr       = w_accept && (bus.cfg_all || !w_chan_bad);
  assign w_lo       = bus.cfg_len < MIN_LEN;
  assign w_hi       = bus.cfg_len > MAX_LEN;
  assign w_len      = w_lo ? MIN_LEN : w_hi ? MAX_LEN : bus.cfg_len;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_mask[g]                   = w_wr && (bus.cfg_all || bus.cfg_chan == CH_W'(g));
    assign bus.filter_len_out[32*g +: 32] = r_len[g];
  end
  assign bus.cfg_ready       = w_idle;
  assign bus.busy            = !w_idle;
  assign bus.commit_ack      = w_apply;
  assign bus.load_filter_len = w_apply ? r_dirty : '0;
  assign bus.clamp_flag      = r_clamp;
  assign bus.chan_err_flag   = r_chan_err;
  always_ff @(posedge clk)
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) r_len[k] <= DEFAULT_LEN;
      r_dirty    <= '0;
      r_clamp    <= 1'b0;
      r_chan_err <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (w_wr_mask[k]) r_len[k] <= w_len;
      r_dirty    <= (w_apply ? '0 : r_dirty) | w_wr_mask;
      r_clamp    <= (w_wr && (w_lo || w_hi)) || (r_clamp && !bus.clear_flags);
      r_chan_err <= (w_accept && !bus.cfg_all && w_chan_bad) || (r_chan_err && !bus.clear_flags);
      r_state    <= w_next;
    end
`ifdef FILTER_SCHED_QUIET_WAIT_EN
  localparam logic [1:0] S_QUIET = 2'd1;
  localparam int         QW      = $clog2(QUIET_CYCLES + 1);
  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_CH-1:0] r_prev;
  logic [QW-1:0]     r_quiet;
  logic [TW-1:0]     r_tmo;
  logic              r_tmo_flag, w_change, w_quiet_ok, w_tmo_hit, w_quiet;
  assign w_quiet          = r_state == S_QUIET;
  assign w_change         = bus.filtered_in != r_prev;
  assign w_quiet_ok       = !w_change && r_quiet == QW'(QUIET_CYCLES - 1);
  assign w_tmo_hit        = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign bus.timeout_flag = r_tmo_flag;
  always_comb w_next = w_idle ? (bus.commit_req ? S_QUIET : S_IDLE) : w_quiet ? (w_quiet_ok || w_tmo_hit ? S_APPLY : S_QUIET) : S_IDLE;
  // a quiet window reached on the timeout cycle takes precedence, so no timeout is reported
  always_ff @(posedge clk)
    if (reset) begin
      r_prev     <= '0;
      r_quiet    <= '0;
      r_tmo      <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_prev     <= bus.filtered_in;
      r_quiet    <= !w_quiet || w_change ? '0 : r_quiet + 1'b1;
      r_tmo      <= !w_quiet ? '0 : r_tmo + 1'b1;
      r_tmo_flag <= (w_quiet && !w_quiet_ok && w_tmo_hit) || (r_tmo_flag && !bus.clear_flags);
    end
`else
  always_comb w_next = w_idle && bus.commit_req ? S_APPLY : S_IDLE;
  assign bus.timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_filter_len_scheduler.sv
// tb_filter_len_scheduler: random config/commit traffic against a window-based reference model with a scoreboard.
// Follows FILTER_SCHED_QUIET_WAIT_EN the same way the design does.
module tb_filter_len_scheduler;
  localparam int          NUM_CH = 3;
  localparam int          CH_W   = 2;
  localparam int          QC     = 4;
  localparam int          TC     = 16;
  localparam logic [31:0] DEFL   = 32'd50000;
  localparam logic [31:0] MINL   = 32'd10;
  localparam logic [31:0] MAXL   = 32'd1000000;

  typedef struct {
    int                   cyc;
    logic [NUM_CH-1:0]    load;
    logic [32*NUM_CH-1:0] lens;
    logic [2:0]           flags;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic [31:0]       m_len [NUM_CH];
  logic [NUM_CH-1:0] m_dirty;
  logic              m_clamp, m_cerr, m_tmo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  filter_len_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();
  filter_len_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DEFAULT_LEN(DEFL), .MIN_LEN(MINL), .MAX_LEN(MAXL),
    .QUIET_CYCLES(QC), .TIMEOUT_CYCLES(TC)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [32*NUM_CH-1:0] pack();
    logic [32*NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[32*k +: 32] = m_len[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) m_len[k] = DEFL;
    m_dirty = '0;
    m_clamp = 1'b0;
    m_cerr  = 1'b0;
    m_tmo   = 1'b0;
  endfunction

  function automatic void model_write(input bit all, input logic [CH_W-1:0] ch, input logic [31:0] len);
    logic [31:0] v;
    v = len < MINL ? MINL : (len > MAXL ? MAXL : len);
    if (all || int'(ch) < NUM_CH) begin
      if (v != len) m_clamp = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        if (all || k == int'(ch)) begin
          m_len[k]   = v;
          m_dirty[k] = 1'b1;
        end
    end else m_cerr = 1'b1;
  endfunction

  function automatic logic [31:0] rand_len();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'($urandom_range(999990, 1000010));
      2:       return $urandom;
      default: return 32'($urandom_range(10, 100000));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_lens"}, 128'(bus.filter_len_out), 128'(pack()));
    chk({tag, "_flags"}, 128'({bus.clamp_flag, bus.chan_err_flag, bus.timeout_flag}), 128'({m_clamp, m_cerr, m_tmo}));
    chk({tag, "_idle"}, 128'({bus.cfg_ready, bus.busy, bus.commit_ack, bus.load_filter_len}),
        128'({3'b100, {NUM_CH{1'b0}}}));
  endtask

  task automatic do_write(input bit all, input logic [CH_W-1:0] ch, input logic [31:0] len, input bit clr);
    if (clr) begin
      m_clamp = 1'b0;
      m_cerr  = 1'b0;
      m_tmo   = 1'b0;
    end
    model_write(all, ch, len);
    bus.cfg_valid   = 1'b1;
    bus.cfg_all     = all;
    bus.cfg_chan    = ch;
    bus.cfg_len     = len;
    bus.clear_flags = clr;
    tick();
    bus.cfg_valid   = 1'b0;
    bus.clear_flags = 1'b0;
    check_state("write");
  endtask

  task automatic do_clear();
    m_clamp = 1'b0;
    m_cerr  = 1'b0;
    m_tmo   = 1'b0;
    bus.clear_flags = 1'b1;
    tick();
    bus.clear_flags = 1'b0;
    check_state("clear");
  endtask

  // mode 0: constant filtered_in, 1: toggling every 2 cycles, 2: sparse random changes
  task automatic do_commit(input int mode, input bit wr, input bit all, input logic [CH_W-1:0] ch, input logic [31:0] len);
    logic [NUM_CH-1:0] hist [TC+3];
    int   off;
    bit   tmo;
    exp_t e;
    hist[0] = bus.filtered_in;
    for (int i = 1; i < TC + 3; i++)
      hist[i] = mode == 0 ? hist[0] :
                mode == 1 ? ((i / 2) % 2 == 1 ? ~hist[0] : hist[0]) :
                ($urandom_range(0, 2) == 0 ? NUM_CH'($urandom) : hist[i-1]);
    off = 1;
    tmo = 1'b0;
`ifdef FILTER_SCHED_QUIET_WAIT_EN
    // apply follows the first waiting cycle that closes QC change-free cycles, else the TC-th waiting cycle
    off = 0;
    for (int k = 0; k < TC; k++)
      if (off == 0) begin
        bit q;
        q = k >= QC - 1;
        if (q)
          for (int j = 0; j < QC; j++)
            if (hist[k-j+1] != hist[k-j]) q = 1'b0;
        if (q) off = k + 2;
        else if (k == TC - 1) begin
          off = k + 2;
          tmo = 1'b1;
        end
      end
`endif
    if (wr) model_write(all, ch, len);
    e.cyc   = cyc + off;
    e.load  = m_dirty;
    e.lens  = pack();
    e.flags = {m_clamp, m_cerr, m_tmo | tmo};
    sbq.push_back(e);
    m_dirty = '0;
    m_tmo   = m_tmo | tmo;
    bus.commit_req = 1'b1;
    bus.cfg_valid  = wr;
    bus.cfg_all    = all;
    bus.cfg_chan   = ch;
    bus.cfg_len    = len;
    for (int i = 0; i < off; i++) begin
      tick();
      bus.commit_req  = 1'b0;
      bus.cfg_valid   = 1'b0;
      bus.filtered_in = hist[i+1];
      chk("busy_window", 128'({bus.cfg_ready, bus.busy}), 128'(2'b01));
      if (i < off - 1 && $urandom_range(0, 1) == 1) begin
        bus.cfg_valid  = 1'b1;
        bus.cfg_all    = 1'b1;
        bus.cfg_len    = $urandom;
        bus.commit_req = 1'b1;
      end
    end
    tick();
    bus.cfg_valid  = 1'b0;
    bus.commit_req = 1'b0;
    check_state("post_commit");
  endtask

  always @(negedge clk) begin
    if (bus.commit_ack) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack at cycle %0d: got ack with load 0x%0h, expected no ack", cyc, bus.load_filter_len);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("apply_cycle", 128'(cyc), 128'(e.cyc));
        chk("apply_load", 128'(bus.load_filter_len), 128'(e.load));
        chk("apply_lens", 128'(bus.filter_len_out), 128'(e.lens));
        chk("apply_flags", 128'({bus.clamp_flag, bus.chan_err_flag, bus.timeout_flag}), 128'(e.flags));
      end
    end else if (bus.load_filter_len != '0) begin
      checks++;
      errors++;
      $display("FAIL load_without_ack at cycle %0d: got 0x%0h, expected 0", cyc, bus.load_filter_len);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_chan    = '0;
    bus.cfg_all     = 1'b0;
    bus.cfg_len     = '0;
    bus.commit_req  = 1'b0;
    bus.clear_flags = 1'b0;
    bus.filtered_in = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    check_state("reset");
    do_commit(0, 1'b0, 1'b0, 2'd0, 32'd0);
    do_write(1'b0, 2'd1, 32'd200, 1'b0);
    do_commit(0, 1'b0, 1'b0, 2'd0, 32'd0);
    do_write(1'b1, 2'd0, 32'd5, 1'b0);
    do_write(1'b0, 2'd2, 32'd2000000, 1'b0);
    do_clear();
    do_write(1'b0, 2'd1, 32'd3, 1'b1);
    do_write(1'b0, 2'd3, 32'd123, 1'b0);
    do_commit(0, 1'b1, 1'b0, 2'd0, 32'd77);
    do_commit(1, 1'b0, 1'b0, 2'd0, 32'd0);
    do_write(1'b1, 2'd0, 32'd4242, 1'b0);
    bus.commit_req = 1'b1;
`ifdef FILTER_SCHED_QUIET_WAIT_EN
    tick();
    bus.commit_req = 1'b0;
    tick();
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.commit_req = 1'b0;
    model_reset();
    check_state("mid_reset");
    repeat (8) tick();
    check_state("post_reset");
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) do_write($urandom_range(0, 4) == 0, CH_W'($urandom_range(0, 3)), rand_len(), 1'b0);
      else if (op == 4) do_write($urandom_range(0, 1) == 1, CH_W'($urandom_range(0, 3)), rand_len(), 1'b1);
      else if (op <= 7) do_commit($urandom_range(0, 2), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                                  CH_W'($urandom_range(0, 3)), rand_len());
      else begin
        bus.filtered_in = NUM_CH'($urandom);
        tick();
      end
    end
    repeat (4) tick();
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/filter_len_scheduler.md
Name: filter_len_scheduler

Overview:
- Configuration controller for a bank of NUM_CH digital input filters (Hall/fault inputs of the BLDC stage).
- Holds a shadow filter length per channel and range-clamps host writes.
- On commit, waits for a quiet window on the filtered signals, then fires one atomic load_filter_len pulse to all dirty channels, so no filter is retuned mid-transition.
- Sits between the AXI register block and the filter instances.

Parameters:
- NUM_CH, 3, number of filter channels (1..16)
- CH_W, 2, width of cfg_chan (must satisfy 2**CH_W >= NUM_CH)
- DEFAULT_LEN, 32'd50000, shadow length after reset
- MIN_LEN, 32'd10, clamp floor
- MAX_LEN, 32'd1000000, clamp ceiling (MIN_LEN <= DEFAULT_LEN <= MAX_LEN)
- QUIET_CYCLES, 64, consecutive unchanged cycles of filtered_in required before apply (>=1)
- TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for quiet (> QUIET_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  host write request
- cfg_ready  out  1  high only in IDLE
- cfg_chan  in  CH_W  target channel
- cfg_all  in  1  write cfg_len to all channels (cfg_chan ignored)
- cfg_len  in  32  requested filter length
- commit_req  in  1  request to apply dirty shadows
- commit_ack  out  1  one-cycle pulse in the apply cycle
- busy  out  1  high in QUIET and APPLY
- filtered_in  in  NUM_CH  filtered outputs of the filter bank (monitored)
- filter_len_out  out  32*NUM_CH  shadow lengths, channel k at [32k+31:32k]
- load_filter_len  out  NUM_CH  per-channel load pulses
- clamp_flag  out  1  sticky: a write was clamped
- chan_err_flag  out  1  sticky: cfg_chan >= NUM_CH
- timeout_flag  out  1  sticky: apply forced by timeout
- clear_flags  in  1  clears all three sticky flags

Behaviour:
- Reset:
  - state=IDLE; all shadows=DEFAULT_LEN; dirty mask=0; filtered_prev=0.
  - load_filter_len=0, commit_ack=0, busy=0, all flags=0; cfg_ready=1 on the first cycle after reset.
- Host writes:
  - Accepted when cfg_valid && cfg_ready. Shadow and dirty bit update on the next edge.
  - Stored value = clamp(cfg_len, MIN_LEN, MAX_LEN), unsigned compare. When clamping occurs, clamp_flag sets.
  - cfg_all writes every channel and sets every dirty bit.
  - cfg_chan >= NUM_CH (with cfg_all=0): no write; chan_err_flag sets.
- filter_len_out is driven directly from the shadows (registered). Filters only latch on a load pulse.
- filtered_prev samples filtered_in every cycle, in all states. change = (filtered_in != filtered_prev).
- FSM IDLE:
  - commit_req -> QUIET; clear quiet_cnt and tmo_cnt.
  - A write and commit_req in the same cycle are both accepted; that commit includes the write.
- FSM QUIET:
  - tmo_cnt increments every cycle. quiet_cnt resets to 0 on change, otherwise increments.
  - When quiet_cnt == QUIET_CYCLES-1 and no change -> APPLY.
  - Else, when tmo_cnt == TIMEOUT_CYCLES-1 -> APPLY and set timeout_flag.
  - If quiet and timeout conditions hit in the same cycle, quiet wins: no timeout_flag.
  - commit_req and cfg_valid are ignored (cfg_ready=0).
- FSM APPLY (1 cycle):
  - load_filter_len = dirty mask; commit_ack=1; dirty mask cleared at the edge; next state IDLE.
  - A commit with dirty=0 still completes the sequence and acks, with no load bits set.
- Latency with constant filtered_in: commit_req sampled at edge T -> APPLY cycle is T+QUIET_CYCLES+1.
- Sticky flags:
  - clear_flags clears them.
  - A set and a clear in the same cycle: set wins.
- Reset mid-QUIET/APPLY: immediate return to IDLE and default shadows; no load pulse in the cycle after reset.

Optional Feature:
- Macro FILTER_SCHED_QUIET_WAIT_EN.
- Defined: QUIET state, counters and timeout_flag behave as above.
- Undefined:
  - QUIET state, counters and timeout logic are not built; timeout_flag is tied to 0.
  - commit_req in IDLE goes directly to APPLY on the next cycle (latency 1). busy is high only in APPLY.

Test Plan (NUM_CH=3, QUIET_CYCLES=4, TIMEOUT_CYCLES=16, MIN_LEN=10, MAX_LEN=1000000, macro defined):
- Reset, no writes, commit_req at cycle 0 with constant filtered_in -> APPLY at cycle 5; commit_ack=1; load_filter_len=3'b000; all lengths 50000.
- Write ch1=200 then commit, filtered_in constant -> load_filter_len=3'b010 for exactly 1 cycle; filter_len_out[63:32]=200; dirty cleared.
- Write cfg_all with len=5, then write ch2 with len=2000000 -> shadows 10/10/1000000; clamp_flag=1. clear_flags -> clamp_flag=0.
- Write cfg_chan=3 -> no shadow change; chan_err_flag=1. Simultaneous write ch0=77 and commit_req -> the apply loads ch0=77.
- Commit with filtered_in toggling every 2 cycles -> apply forced at tmo_cnt=15; timeout_flag=1; load pulse issued; cfg_ready stays 0 throughout QUIET.
- Reset asserted during QUIET with dirty=3'b111 -> next cycle IDLE; cfg_ready=1; no load pulse; shadows=50000.
